// File: rtl/sha_1_pad.sv
// sha_1_pad: message padder in front of the SHA-1 compression core.
// Collects 32-bit big-endian message words into 512-bit blocks and appends
// the 0x80 marker, zero fill and 64-bit bit length. Each block is handed to
// the core with a one-cycle Enable pulse. The next block is only started
// after the core answers with Ready.
module sha_1_pad #(
    parameter int LEN_W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  in_data,
    input  logic [2:0]   in_nbytes,
    input  logic         in_last,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [511:0] Data,
    output logic [63:0]  Index,
    output logic         Enable,
    input  logic         Ready,
    output logic         done,
    output logic         busy,
    output logic [1:0]   dbg_state
);

    // Input handshake: a word transfers on a rising clk edge where
    // in_valid && in_ready. in_ready is a registered output and is high only
    // in FILL. While in_ready is low, in_valid is ignored. Upstream keeps
    // in_data/in_nbytes/in_last stable until the transfer happens.

    typedef enum logic [1:0] {
        FILL = 2'd0,
        PAD  = 2'd1,
        SEND = 2'd2,
        WAIT = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         wc_q, wc_d;          // next block word to fill
    logic [4:0]         p_q, p_d;            // word holding the 0x80 (16 = next block)
    logic [LEN_W-1:0]   bitlen_q, bitlen_d;
    logic [63:0]        index_q, index_d;
    logic [511:0]       data_q, data_d;
    logic               enable_q, enable_d;
    logic               in_ready_q, in_ready_d;
    logic               final_q, final_d;    // current block carries the length
    logic               extra_q, extra_d;    // a length-only block must follow
    logic               pend_q, pend_d;      // 0x80 not yet placed (goes in extra block)

    logic               xfer;
    logic [31:0]        word_w;
    logic [3:0]         wc_nx;
    logic [63:0]        len64;

    // Keep only the valid leading bytes of a word.
    function automatic logic [31:0] mask_bytes(input logic [31:0] d, input logic [2:0] nb);
        logic [31:0] r;
        case (nb)
            3'd0:    r = 32'h0000_0000;
            3'd1:    r = {d[31:24], 24'h00_0000};
            3'd2:    r = {d[31:16], 16'h0000};
            3'd3:    r = {d[31:8], 8'h00};
            default: r = d;
        endcase
        return r;
    endfunction

    // 0x80 marker placed right after nb valid bytes within the same word.
    function automatic logic [31:0] marker_word(input logic [2:0] nb);
        logic [31:0] r;
        case (nb)
            3'd0:    r = 32'h8000_0000;
            3'd1:    r = 32'h0080_0000;
            3'd2:    r = 32'h0000_8000;
            3'd3:    r = 32'h0000_0080;
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    assign len64 = 64'(bitlen_q);
    assign xfer  = in_valid && in_ready_q && (state_q == FILL);
    assign wc_nx = wc_q + 4'd1;

    // Next-state and datapath update for the padding FSM.
    always_comb begin
        state_d  = state_q;
        wc_d     = wc_q;
        p_d      = p_q;
        bitlen_d = bitlen_q;
        index_d  = index_q;
        data_d   = data_q;
        final_d  = final_q;
        extra_d  = extra_q;
        pend_d   = pend_q;
        word_w   = mask_bytes(in_data, in_nbytes);

        case (state_q)
            FILL: begin
                if (xfer) begin
                    bitlen_d = bitlen_q + LEN_W'({in_nbytes, 3'b000});
                    if (in_last) begin
                        if (in_nbytes < 3'd4) begin
                            word_w = word_w | marker_word(in_nbytes);
                            p_d    = {1'b0, wc_q};
                        end else begin
                            p_d = {1'b0, wc_q} + 5'd1;
                            // A full last word in word 15 pushes the marker
                            // into the extra block.
                            if (wc_q != 4'd15) begin
                                data_d[{wc_nx, 5'd0} +: 32] = 32'h8000_0000;
                            end
                        end
                        data_d[{wc_q, 5'd0} +: 32] = word_w;
                        state_d = PAD;
                    end else begin
                        data_d[{wc_q, 5'd0} +: 32] = word_w;
                        wc_d = wc_nx;
                        if (wc_q == 4'd15) begin
                            final_d = 1'b0;
                            extra_d = 1'b0;
                            pend_d  = 1'b0;
                            state_d = SEND;
                        end
                    end
                end
            end

            PAD: begin
                for (int w = 0; w < 16; w++) begin
                    if (w > int'(p_q)) begin
                        data_d[9'(w * 32) +: 32] = 32'h0000_0000;
                    end
                end
                if (p_q <= 5'd13) begin
                    data_d[479:448] = len64[63:32];
                    data_d[511:480] = len64[31:0];
                    final_d = 1'b1;
                    extra_d = 1'b0;
                    pend_d  = 1'b0;
                end else begin
                    final_d = 1'b0;
                    extra_d = 1'b1;
                    pend_d  = (p_q == 5'd16);
                end
                state_d = SEND;
            end

            SEND: begin
                state_d = WAIT;
            end

            WAIT: begin
                if (Ready) begin
                    if (final_q) begin
                        index_d  = 64'd0;
                        bitlen_d = '0;
                        wc_d     = 4'd0;
                        final_d  = 1'b0;
                        state_d  = FILL;
                    end else if (extra_q) begin
                        data_d          = '0;
                        data_d[31:0]    = pend_q ? 32'h8000_0000 : 32'h0000_0000;
                        data_d[479:448] = len64[63:32];
                        data_d[511:480] = len64[31:0];
                        index_d = index_q + 64'd1;
                        final_d = 1'b1;
                        extra_d = 1'b0;
                        pend_d  = 1'b0;
                        state_d = SEND;
                    end else begin
                        index_d = index_q + 64'd1;
                        wc_d    = 4'd0;
                        state_d = FILL;
                    end
                end
            end

            default: state_d = FILL;
        endcase

        enable_d   = (state_d == SEND);
        in_ready_d = (state_d == FILL);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= FILL;
            wc_q       <= 4'd0;
            p_q        <= 5'd0;
            bitlen_q   <= '0;
            index_q    <= 64'd0;
            data_q     <= '0;
            enable_q   <= 1'b0;
            in_ready_q <= 1'b0;
            final_q    <= 1'b0;
            extra_q    <= 1'b0;
            pend_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wc_q       <= wc_d;
            p_q        <= p_d;
            bitlen_q   <= bitlen_d;
            index_q    <= index_d;
            data_q     <= data_d;
            enable_q   <= enable_d;
            in_ready_q <= in_ready_d;
            final_q    <= final_d;
            extra_q    <= extra_d;
            pend_q     <= pend_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign Data      = data_q;
    assign Index     = index_q;
    assign Enable    = enable_q;
    // done coincides with the core's Ready on the last block, when Hash is valid.
    assign done      = rst && (state_q == WAIT) && Ready && final_q;
    assign busy      = (state_q != FILL) || (wc_q != 4'd0) || (index_q != 64'd0);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_sha_1_pad.sv
// Testbench for sha_1_pad: drives messages from a vector table, models the
// SHA-1 core (compression + Ready pulse) and scoreboards each padded block.
module tb_sha_1_pad;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  in_data;
    logic [2:0]   in_nbytes;
    logic         in_last;
    logic         in_valid;
    logic         in_ready;
    logic [511:0] Data;
    logic [63:0]  Index;
    logic         Enable;
    logic         Ready;
    logic         done;
    logic         busy;
    logic [1:0]   dbg_state;

    localparam logic [159:0] IV = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;

    typedef struct {
        string        s;
        int           glen;
        logic [159:0] hash;
        bit           chk;
        int           nblk;
        bit           hold;
    } vec_t;

    vec_t         vecs[10];
    logic [575:0] exp_q[$];      // {Index, Data} per expected block
    logic [575:0] exp_blk;
    int           n_chk = 0;
    int           n_fail = 0;
    int           n_enable = 0;
    int           done_cnt = 0;
    int           tail_msg = 0;
    int           ready_cnt;
    bit           blk_active;
    bit           hold_ready = 1'b0;
    bit           cur_chk = 1'b0;
    logic [159:0] cur_hash = '0;
    logic [159:0] core_h;

    sha_1_pad #(.LEN_W(64)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_nbytes(in_nbytes), .in_last(in_last),
        .in_valid(in_valid), .in_ready(in_ready),
        .Data(Data), .Index(Index), .Enable(Enable), .Ready(Ready),
        .done(done), .busy(busy), .dbg_state(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [575:0] act, input logic [575:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [159:0] sha1_compress(input logic [159:0] h, input logic [511:0] blk);
        logic [31:0] w [80];
        logic [31:0] a, b, c, d, e, f, k, t;
        for (int i = 0; i < 16; i++) w[i] = blk[i*32 +: 32];
        for (int i = 16; i < 80; i++) w[i] = rotl(w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16], 1);
        {a, b, c, d, e} = h;
        for (int i = 0; i < 80; i++) begin
            if (i < 20) begin
                f = (b & c) | (~b & d); k = 32'h5A827999;
            end else if (i < 40) begin
                f = b ^ c ^ d; k = 32'h6ED9EBA1;
            end else if (i < 60) begin
                f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC;
            end else begin
                f = b ^ c ^ d; k = 32'hCA62C1D6;
            end
            t = rotl(a, 5) + f + e + k + w[i];
            e = d; d = c; c = rotl(b, 30); b = a; a = t;
        end
        return {h[159:128] + a, h[127:96] + b, h[95:64] + c, h[63:32] + d, h[31:0] + e};
    endfunction

    function automatic vec_t mk(input string s, input int glen, input logic [159:0] hash,
                                input bit chk, input int nblk, input bit hold);
        vec_t v;
        v.s = s; v.glen = glen; v.hash = hash; v.chk = chk; v.nblk = nblk; v.hold = hold;
        return v;
    endfunction

    // Reference padding: message bytes, 0x80, zeros to 56 mod 64, 64-bit length.
    task automatic push_expected(input logic [7:0] b[$]);
        logic [7:0]   p[$];
        logic [63:0]  lenbits;
        logic [511:0] blk;
        p = b;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        lenbits = 64'(b.size()) * 64'd8;
        for (int j = 7; j >= 0; j--) p.push_back(lenbits[j*8 +: 8]);
        for (int k = 0; k < p.size() / 64; k++) begin
            blk = '0;
            for (int w = 0; w < 16; w++) begin
                blk[w*32 +: 32] = {p[64*k+4*w], p[64*k+4*w+1], p[64*k+4*w+2], p[64*k+4*w+3]};
            end
            exp_q.push_back({64'(k), blk});
        end
    endtask

    // Driver: present one word and hold it until the handshake completes.
    task automatic send_word(input logic [31:0] d, input logic [2:0] nb, input bit last);
        bit ok = 1'b0;
        in_data = d; in_nbytes = nb; in_last = last; in_valid = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        if (!ok) begin
            n_chk++; n_fail++;
            $display("FAIL handshake_timeout: got in_ready 0 for 2000 cycles, required 1");
        end
    endtask

    // Driver: send a byte message as words; invalid tail bytes carry junk.
    task automatic drive_msg(input logic [7:0] b[$], input bit hold);
        int n, nw, nb;
        logic [31:0] word;
        n  = b.size();
        nw = (n == 0) ? 1 : (n + 3) / 4;
        for (int k = 0; k < nw; k++) begin
            nb   = (n - 4*k > 4) ? 4 : n - 4*k;
            word = $urandom;
            for (int j = 0; j < nb; j++) word[31-8*j -: 8] = b[4*k+j];
            send_word(word, 3'(nb), k == nw - 1);
            if (!hold) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic get_bytes(input vec_t v, output logic [7:0] b[$]);
        b = {};
        if (v.s.len() > 0) begin
            for (int i = 0; i < v.s.len(); i++) b.push_back(v.s[i]);
        end else begin
            for (int i = 0; i < v.glen; i++) b.push_back(8'((i * 13 + 5) % 256));
        end
    endtask

    task automatic run_msg(input vec_t v);
        logic [7:0] b[$];
        int en0, d0;
        get_bytes(v, b);
        push_expected(b);
        cur_hash = v.hash; cur_chk = v.chk;
        en0 = n_enable; d0 = done_cnt;
        drive_msg(b, v.hold);
        tail_msg = d0 + 1;
        for (int c = 0; c < 3000; c++) begin
            if (done_cnt != d0) break;
            @(posedge clk);
        end
        repeat (8) @(posedge clk);
        #1;
        check("done_once", done_cnt, d0 + 1);
        check("block_count", n_enable - en0, v.nblk);
        check("blocks_left", exp_q.size(), 0);
        exp_q.delete();
        tail_msg = done_cnt;
    endtask

    // Core model + scoreboard consumer: checks blocks on Enable, hashes them,
    // answers with Ready after a random delay and checks Hash on done.
    initial begin
        Ready = 1'b0; ready_cnt = 0; blk_active = 1'b0; core_h = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                ready_cnt  = 0;
                blk_active = 1'b0;
            end else begin
                if (blk_active || tail_msg > done_cnt) check("in_ready_low", in_ready, 1'b0);
                if (Ready) blk_active = 1'b0;
                if (done) begin
                    check("done_with_ready", Ready, 1'b1);
                    check("done_after_last_block", exp_q.size(), 0);
                    if (cur_chk) check("hash", core_h, cur_hash);
                    done_cnt++;
                end
                if (Enable) begin
                    n_enable++;
                    if (exp_q.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL unexpected_block: got Index %0d, required no block", Index);
                    end else begin
                        exp_blk = exp_q.pop_front();
                        check("block", {Index, Data}, exp_blk);
                    end
                    core_h     = sha1_compress((Index == 64'd0) ? IV : core_h, Data);
                    blk_active = 1'b1;
                    ready_cnt  = $urandom_range(1, 4);
                end
            end
            @(posedge clk); #1;
            Ready = 1'b0;
            if (ready_cnt > 0 && !hold_ready) begin
                ready_cnt--;
                if (ready_cnt == 0) Ready = 1'b1;
            end
        end
    end

    // Main sequence
    initial begin
        logic [7:0] b[$];
        int en0;

        vecs[0] = mk("abc", 0, 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d, 1, 1, 0);
        vecs[1] = mk("", 0, 160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709, 1, 1, 0);
        vecs[2] = mk("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", 0,
                     160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1, 1, 2, 0);
        vecs[3] = mk("", 64, '0, 0, 2, 0);
        vecs[4] = mk("", 120, '0, 0, 3, 1);
        vecs[5] = mk("", 61, '0, 0, 2, 0);
        vecs[6] = mk("", 55, '0, 0, 1, 0);
        vecs[7] = mk("", 52, '0, 0, 1, 0);
        vecs[8] = mk("", 60, '0, 0, 2, 1);
        vecs[9] = mk("", 68, '0, 0, 2, 0);

        rst = 1'b0; in_valid = 1'b0; in_data = '0; in_nbytes = '0; in_last = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_enable", Enable, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_index", Index, 64'd0);
        check("rst_data", Data, 512'd0);
        check("rst_state", dbg_state, 2'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("in_ready_after_rst", in_ready, 1'b1);
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) run_msg(vecs[i]);

        // Reset while the core is working on block 0 of a two-block message.
        hold_ready = 1'b1;
        get_bytes(vecs[2], b);
        push_expected(b);
        en0 = n_enable;
        drive_msg(b, 1'b0);
        tail_msg = done_cnt + 1;
        for (int c = 0; c < 200; c++) begin
            if (n_enable != en0) break;
            @(posedge clk);
        end
        repeat (3) @(posedge clk);
        #1;
        check("wait_before_rst", dbg_state, 2'd3);
        check("busy_in_wait", busy, 1'b1);
        rst = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_enable", Enable, 1'b0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_in_ready", in_ready, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_index", Index, 64'd0);
        check("mid_rst_data", Data, 512'd0);
        check("mid_rst_state", dbg_state, 2'd0);
        exp_q.delete();
        tail_msg   = done_cnt;
        hold_ready = 1'b0;
        rst        = 1'b1;
        @(posedge clk); #1;
        check("in_ready_after_mid_rst", in_ready, 1'b1);
        run_msg(vecs[0]);
        run_msg(vecs[2]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, required finish");
        $fatal(1, "watchdog expired");
    end

endmodule
